// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for a word-wide data memory.
// Sub-word stores use a two-cycle read-modify-write; loads are extended one cycle after the read.
module mem_access_unit #(
  parameter int NB_ADDR = 5,
  parameter int NB_DATA = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [NB_ADDR+1:0]   i_byte_addr,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [NB_DATA-1:0]   i_store_data,
  output logic                 o_stall,
  output logic [NB_DATA-1:0]   o_load_data,
  output logic                 o_load_valid,
  output logic                 o_misaligned,
  output logic                 o_mem_enable,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [NB_ADDR-1:0]   o_mem_address,
  output logic [NB_DATA-1:0]   o_mem_write_data,
  input  logic [NB_DATA-1:0]   i_mem_read_data
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WAIT} state_t;

  state_t             r_state;
  logic [1:0]         r_off;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_store_data;
  logic [NB_DATA-1:0] r_load_data;
  logic               r_load_valid;
  logic               r_misaligned;

  logic               w_req;
  logic               w_illegal;
  logic               w_acc;
  logic               w_rd;
  logic               w_sw;
  logic               w_sub;
  logic               w_act;
  logic               w_rmw;
  logic [NB_ADDR-1:0] w_word;
  logic [4:0]         w_shift;
  logic [NB_DATA-1:0] w_mask;
  logic [NB_DATA-1:0] w_merged;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [NB_DATA-1:0] w_ext;

  assign w_word    = i_byte_addr[NB_ADDR+1:2];
  assign w_req     = i_reset_n && i_valid && (i_mem_read || i_mem_write) && r_state == IDLE;
  assign w_illegal = (i_size == 2'b10) || (i_size == 2'b01 && i_byte_addr[0])
                     || (i_size == 2'b11 && i_byte_addr[1:0] != 2'b00);
  assign w_acc     = w_req && !w_illegal;
  // write wins when both read and write are requested
  assign w_rd      = w_acc && !i_mem_write;
  assign w_sw      = w_acc && i_mem_write && i_size == 2'b11;
  assign w_sub     = w_acc && i_mem_write && i_size != 2'b11;
  assign w_act     = w_rd || w_sw || w_sub;
  assign w_rmw     = r_state == RMW_WAIT;

  assign w_shift   = {r_off, 3'b000};
  assign w_mask    = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged  = (i_mem_read_data & ~w_mask) | ((r_store_data << w_shift) & w_mask);

  assign w_byte    = 8'(i_mem_read_data >> w_shift);
  assign w_half    = r_off[1] ? i_mem_read_data[31:16] : i_mem_read_data[15:0];
  assign w_ext     = r_size == 2'b00 ? (r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte})
                   : r_size == 2'b01 ? (r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half})
                   : i_mem_read_data;

  assign o_stall          = r_state != IDLE || w_rd || w_sub;
  assign o_mem_enable     = w_act || w_rmw;
  assign o_mem_read       = w_rd || w_sub;
  assign o_mem_write      = w_sw || w_rmw;
  assign o_mem_address    = w_rmw ? r_addr : w_act ? w_word : '0;
  assign o_mem_write_data = w_rmw ? w_merged : w_sw ? i_store_data : '0;
  assign o_load_data      = r_load_data;
  assign o_load_valid     = r_load_valid;
  assign o_misaligned     = r_misaligned;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_off        <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_load_valid <= r_state == LOAD_WAIT;
      r_misaligned <= w_req && w_illegal;
      case (r_state)
        IDLE: begin
          if (w_rd || w_sub) begin
            r_off        <= i_byte_addr[1:0];
            r_size       <= i_size;
            r_unsigned   <= i_unsigned;
            r_addr       <= w_word;
            r_store_data <= i_store_data;
            r_state      <= w_rd ? LOAD_WAIT : RMW_WAIT;
          end
        end
        LOAD_WAIT: begin
          r_load_data <= w_ext;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, RMW stores, misalignment and reset abandonment.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, rd, wr, uns;
  logic [6:0]  baddr;
  logic [1:0]  size;
  logic [31:0] sdata;
  logic        stall, lvalid, mis, en, mrd, mwr;
  logic [31:0] ldata, wdata;
  logic [4:0]  maddr;
  logic [31:0] rdata;
  logic [31:0] mem [32];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .i_mem_read(rd), .i_mem_write(wr),
    .i_byte_addr(baddr), .i_size(size), .i_unsigned(uns), .i_store_data(sdata),
    .o_stall(stall), .o_load_data(ldata), .o_load_valid(lvalid), .o_misaligned(mis),
    .o_mem_enable(en), .o_mem_read(mrd), .o_mem_write(mwr), .o_mem_address(maddr),
    .o_mem_write_data(wdata), .i_mem_read_data(rdata)
  );

  always @(posedge clk) begin
    if (mwr) mem[maddr] <= wdata;
    rdata <= (en && mrd) ? mem[maddr] : 32'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic r, input logic w, input logic [6:0] a, input logic [1:0] s,
                     input logic u, input logic [31:0] d);
    valid = 1'b1; rd = r; wr = w; baddr = a; size = s; uns = u; sdata = d;
  endtask

  task automatic idle();
    valid = 1'b0; rd = 1'b0; wr = 1'b0; baddr = '0; size = '0; uns = 1'b0; sdata = '0;
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input string tag, input logic [6:0] a, input logic [1:0] s,
                      input logic u, input logic [31:0] exp);
    req(1'b1, 1'b0, a, s, u, 32'd0);
    #1;
    chk({tag, "_stall_t"}, {31'd0, stall}, 32'd1);
    chk({tag, "_rd_t"}, {29'd0, en, mrd, mwr}, 32'd6);
    next(); idle();
    chk({tag, "_stall_t1"}, {31'd0, stall}, 32'd1);
    next();
    chk({tag, "_valid_t2"}, {31'd0, lvalid}, 32'd1);
    chk({tag, "_data"}, ldata, exp);
    chk({tag, "_stall_t2"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic bad(input string tag, input logic r, input logic w, input logic [6:0] a,
                     input logic [1:0] s);
    req(r, w, a, s, 1'b0, 32'hFFFF_FFFF);
    #1;
    chk({tag, "_mem_t"}, {28'd0, en, mrd, mwr, stall}, 32'd0);
    next(); idle();
    chk({tag, "_mis_t1"}, {28'd0, mis, en, mwr, stall}, 32'd8);
    next();
    chk({tag, "_mis_t2"}, {31'd0, mis}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[1] = 32'h1122_3344;
    mem[3] = 32'h8822_F344;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_outs", {25'd0, stall, lvalid, mis, en, mrd, mwr, 1'b0}, 32'd0);
    chk("reset_ldata", ldata, 32'd0);
    rst_n = 1'b1;
    next();
    chk("idle_mem", {maddr, wdata[26:0]}, 32'd0);

    load("lb", 7'h0D, 2'b00, 1'b0, 32'hFFFF_FFF3);
    next();
    chk("lb_hold", ldata, 32'hFFFF_FFF3);
    chk("lb_pulse", {31'd0, lvalid}, 32'd0);
    load("lbu", 7'h0D, 2'b00, 1'b1, 32'h0000_00F3);

    req(1'b0, 1'b1, 7'h0E, 2'b00, 1'b0, 32'h0000_00AB);
    #1;
    chk("sb_t", {28'd0, en, mrd, mwr, stall}, 32'd13);
    chk("sb_addr_t", {27'd0, maddr}, 32'd3);
    next(); idle();
    chk("sb_t1", {28'd0, en, mrd, mwr, stall}, 32'd11);
    chk("sb_addr_t1", {27'd0, maddr}, 32'd3);
    chk("sb_wdata", wdata, 32'h88AB_F344);
    next();
    load("lw_after_sb", 7'h0C, 2'b11, 1'b0, 32'h88AB_F344);

    bad("sh_odd", 1'b0, 1'b1, 7'h0D, 2'b01);
    bad("lw_off2", 1'b1, 1'b0, 7'h0E, 2'b11);
    bad("size10", 1'b1, 1'b0, 7'h0C, 2'b10);
    bad("rdwr_size10", 1'b1, 1'b1, 7'h0C, 2'b10);
    chk("mem3_unchanged", mem[3], 32'h88AB_F344);

    req(1'b0, 1'b1, 7'h08, 2'b11, 1'b0, 32'hDEAD_BEEF);
    #1;
    chk("sw_t", {28'd0, en, mrd, mwr, stall}, 32'd10);
    chk("sw_addr", {27'd0, maddr}, 32'd2);
    chk("sw_wdata", wdata, 32'hDEAD_BEEF);
    next();
    load("lh_after_sw", 7'h0A, 2'b01, 1'b0, 32'hFFFF_DEAD);
    load("lhu_lo", 7'h08, 2'b01, 1'b1, 32'h0000_BEEF);
    load("lb3", 7'h0B, 2'b00, 1'b0, 32'hFFFF_FFDE);
    chk("ldata_nonzero", ldata, 32'hFFFF_FFDE);

    req(1'b0, 1'b1, 7'h04, 2'b00, 1'b0, 32'h0000_0055);
    next(); idle();
    chk("rmw_before_rst", {31'd0, mwr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_outs", {26'd0, stall, lvalid, mis, en, mrd, mwr}, 32'd0);
    chk("rst_rmw_ldata", ldata, 32'd0);
    chk("rst_rmw_addr", {maddr, wdata[26:0]}, 32'd0);
    next();
    rst_n = 1'b1;
    next();
    chk("mem1_unchanged", mem[1], 32'h1122_3344);
    chk("no_valid_after_rst", {30'd0, lvalid, stall}, 32'd0);
    load("lw_after_rst", 7'h04, 2'b11, 1'b0, 32'h1122_3344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
